hazard_sched: RTL
=================

# hazard_sched

Pipeline hazard controller for the five-stage RISC-V core. It sits beside the F/D/E/M/W pipeline registers and drives their stall and flush controls and the execute-stage operand forwarding selects. It sequences three hazard classes: load-use stalls, branch/jump redirects, and multi-cycle data-memory waits. It also keeps a stall performance counter and a sticky memory-timeout flag.

## Interface
- TIMEOUT, default 255, maximum number of consecutive MEM_WAIT cycles before `mem_timeout` sets (range 1..65535).
- CNT_W, default 32, width of `stall_cycles`.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rs1D, rs2D  in  5  source register numbers of the instruction in Decode
- rs1E, rs2E, RdE  in  5  source and destination register numbers in Execute
- ResultSrcE  in  2  result select in Execute; `01` = load
- PCSrcE  in  1  taken branch, jal or jalr resolved in Execute
- RdM, RdW  in  5  destination register numbers in Memory and Writeback
- RegWriteM, RegWriteW  in  1  write enables in Memory and Writeback
- MemReqM  in  1  load or store active in Memory
- dmem_ready  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the PC register and the D, E and M pipeline registers
- FlushD, FlushE, FlushW  out  1  load a bubble (all zero) into the D, E and W registers
- ForwardAE, ForwardBE  out  2  operand select: `00` register file, `01` W result, `10` M ALU result
- mem_timeout  out  1  sticky error flag
- stall_cycles  out  CNT_W  count of cycles with StallF asserted

## Operation
- Forwarding is combinational and independent of state.
  - ForwardAE = `10` if RegWriteM && RdM≠0 && RdM==rs1E.
  - Otherwise `01` if RegWriteW && RdW≠0 && RdW==rs1E.
  - Otherwise `00`.
  - ForwardBE uses the same rule with rs2E.
- lw_hit = (ResultSrcE==`01`) && RdE≠0 && (RdE==rs1D || RdE==rs2D).
- State machine states: RUN, LU_STALL, MEM_WAIT. Reset state is RUN.
- Transitions, evaluated in this priority order:
  - MemReqM && !dmem_ready → MEM_WAIT, from any state.
  - Else PCSrcE → RUN. The redirect overrides a pending load-use hit.
  - Else lw_hit in RUN → LU_STALL.
  - LU_STALL → RUN unconditionally after exactly one cycle.
  - MEM_WAIT → RUN on dmem_ready.
- Outputs in RUN:
  - PCSrcE: FlushD=1 and FlushE=1, no stalls.
  - lw_hit and !PCSrcE: StallF=1, StallD=1, FlushE=1.
  - Otherwise all stall and flush outputs are 0.
- Outputs in LU_STALL: all stall and flush outputs 0. The dependent instruction advances and its operand is forwarded from W.
- Outputs in MEM_WAIT (and in RUN on the entry cycle when MemReqM && !dmem_ready): StallF, StallD, StallE and StallM = 1, FlushW=1. FlushD and FlushE are 0 even if PCSrcE=1; the redirect is re-evaluated when Execute releases.
- Wait counter: wait_cnt is 16 bits. It increments every cycle MemReqM && !dmem_ready and clears otherwise. When it reaches TIMEOUT, mem_timeout sets and stays set until rst. The FSM keeps waiting.
- stall_cycles increments each cycle StallF=1. It saturates at all-ones with no wrap.

## Timing
- Stall, flush and forward outputs are combinational from current state and inputs, with zero-cycle latency.
- State, wait_cnt, mem_timeout and stall_cycles update on posedge clk.
- While rst is high:
  - all Stall outputs 0;
  - FlushD, FlushE and FlushW = 1;
  - ForwardAE and ForwardBE = `00`;
  - mem_timeout 0, stall_cycles 0, state RUN.
- Load-use costs exactly one bubble. The cycle after the stall, lw_hit must not re-trigger, which the LU_STALL state guarantees.
- Branch penalty is two cycles (D and E flushed in the resolve cycle).
- dmem_ready arriving in the same cycle as MemReqM causes no stall.
- Reset asserted mid-MEM_WAIT aborts the wait immediately and asynchronously.

## Structure
- Shared package `core_pkg` holds:
  - RESULT_LOAD = 2'b01;
  - forwarding encodings FWD_RF, FWD_W, FWD_M;
  - the state enum type.
- One sub-module, `fwd_unit`, holds the pure combinational forwarding compare. It is instantiated once per operand (A, B).

## Test plan
- RdM=5, RegWriteM=1, rs1E=5, and RdW=5, RegWriteW=1 simultaneously → ForwardAE=`10` (M has priority). With RdM=0 instead → `01`.
- Load in E with RdE=3 and rs2D=3 → one cycle of StallF=StallD=FlushE=1, then the next cycle all 0 in LU_STALL; stall_cycles increases by 1.
- PCSrcE=1 in the same cycle as lw_hit → FlushD=FlushE=1, StallF=0, state stays RUN.
- MemReqM=1 with dmem_ready low for 4 cycles then high → StallF/D/E/M and FlushW high for 4 cycles, all low in the ready cycle; stall_cycles=4.
- TIMEOUT=3 with dmem_ready held low → mem_timeout rises on the edge where wait_cnt reaches 3 and stays set after ready arrives; only rst clears it.
- rst asserted mid-MEM_WAIT → outputs take their reset values immediately without waiting for clk; after release the state is RUN.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline control blocks.
package core_pkg;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hazState_t;

endpackage

// File: rtl/hazard_sched_fwd_unit.sv
// Execute-stage operand forwarding select for one source operand.
module fwd_unit
    import core_pkg::*;
(
    input  logic [4:0] rsE,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic [1:0] fwdSel
);

    // The M result is younger than the W result, so it wins when both match.
    always_comb begin
        fwdSel = FWD_RF;
        if (RegWriteM && (RdM != 5'd0) && (RdM == rsE))
            fwdSel = FWD_M;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rsE))
            fwdSel = FWD_W;
    end

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard controller: load-use stall, branch redirect, data-memory wait,
// operand forwarding, stall cycle counter and sticky memory-timeout flag.
//
// state    | meaning
// RUN      | normal flow; redirects flush D/E, load-use hits stall F/D
// LU_STALL | one bubble inserted; dependent instruction advances this cycle
// MEM_WAIT | data memory busy; F/D/E/M held, W bubbled
module hazard_sched
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

    hazState_t   state;
    hazState_t   nextState;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic        lwHit;
    logic        memStall;
    logic [15:0] waitCnt;
    logic [15:0] waitNext;

    fwd_unit uFwdA (
        .rsE       (rs1E),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .RdW       (RdW),
        .RegWriteW (RegWriteW),
        .fwdSel    (fwdA)
    );

    fwd_unit uFwdB (
        .rsE       (rs2E),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .RdW       (RdW),
        .RegWriteW (RegWriteW),
        .fwdSel    (fwdB)
    );

    assign ForwardAE = rst ? FWD_RF : fwdA;
    assign ForwardBE = rst ? FWD_RF : fwdB;

    assign lwHit    = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                      ((RdE == rs1D) || (RdE == rs2D));
    assign memStall = MemReqM && !dmem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= nextState;
    end

    // A memory wait freezes E, so any redirect there is simply held and
    // re-seen when the wait releases; the release cycle behaves like RUN.
    always_comb begin
        nextState = state;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (rst) begin
            nextState = RUN;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
        end else if (memStall) begin
            nextState = MEM_WAIT;
            StallF    = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            StallM    = 1'b1;
            FlushW    = 1'b1;
        end else if (state == LU_STALL) begin
            nextState = RUN;
        end else if (PCSrcE) begin
            nextState = RUN;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
        end else if (lwHit) begin
            nextState = LU_STALL;
            StallF    = 1'b1;
            StallD    = 1'b1;
            FlushE    = 1'b1;
        end else begin
            nextState = RUN;
        end
    end

    assign waitNext = (waitCnt == 16'hFFFF) ? waitCnt : waitCnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt     <= 16'd0;
            mem_timeout <= 1'b0;
        end else if (memStall) begin
            waitCnt <= waitNext;
            if (waitNext >= TIMEOUT_V)
                mem_timeout <= 1'b1;
        end else begin
            waitCnt <= 16'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (StallF && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule
